// File: rtl/imem_loader.sv
// imem_loader: 2**AWIDTH x IWIDTH instruction memory filled by a 1-bit serial loader; holds the core in reset until loaded.
// Define LOADER_PARITY_EN to append an even-parity bit to every word and enable the ERR state.
module imem_loader #(
    parameter int AWIDTH = 8,
    parameter int IWIDTH = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic              sin_valid,
    input  logic              sin,
    input  logic [AWIDTH-1:0] cpu_adr,
    output logic [IWIDTH-1:0] instruct,
    output logic              cpu_reset,
    output logic              load_busy,
    output logic              load_done,
    output logic              parity_err
);
    localparam int DEPTH = 2**AWIDTH;
`ifdef LOADER_PARITY_EN
    localparam int WBITS = IWIDTH + 1;
`else
    localparam int WBITS = IWIDTH;
`endif
    localparam int SW   = WBITS - 1;
    localparam int CMAX = (AWIDTH > WBITS) ? AWIDTH : WBITS;
    localparam int CW   = $clog2(CMAX);
    localparam logic [CW-1:0] LEN_LAST  = CW'(AWIDTH - 1);
    localparam logic [CW-1:0] WORD_LAST = CW'(WBITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_LOAD, S_RUN, S_ERR} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       bitcnt_q, bitcnt_d;
    logic [AWIDTH-1:0]   len_q, len_d;
    logic [AWIDTH-1:0]   wr_adr_q, wr_adr_d;
    logic [SW-1:0]       shift_q, shift_d;
    logic                cpu_reset_q, load_busy_q, load_done_q;
    logic [WBITS-1:0]    word;
    logic [IWIDTH-1:0]   wdata;
    logic                word_ok;
    logic                we;
    logic [IWIDTH-1:0]   mem [DEPTH];

    // The completing bit is still on sin, so the word is assembled from the shift register plus sin.
    assign word = {shift_q, sin};
`ifdef LOADER_PARITY_EN
    assign wdata   = word[WBITS-1:1];
    assign word_ok = ~^word;
`else
    assign wdata   = word;
    assign word_ok = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        len_d    = len_q;
        wr_adr_d = wr_adr_q;
        shift_d  = shift_q;
        we       = 1'b0;
        if (load_req) begin
            state_d  = S_LEN;
            bitcnt_d = '0;
            len_d    = '0;
            wr_adr_d = '0;
            shift_d  = '0;
        end else if (sin_valid) begin
            case (state_q)
                S_LEN: begin
                    len_d = {len_q[AWIDTH-2:0], sin};
                    if (bitcnt_q == LEN_LAST) begin
                        state_d  = S_LOAD;
                        bitcnt_d = '0;
                        wr_adr_d = '0;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
                S_LOAD: begin
                    shift_d = {shift_q[SW-2:0], sin};
                    if (bitcnt_q == WORD_LAST) begin
                        bitcnt_d = '0;
                        if (word_ok) begin
                            we       = 1'b1;
                            wr_adr_d = wr_adr_q + 1'b1;
                            if (wr_adr_q == len_q) state_d = S_RUN;
                        end else begin
                            state_d = S_ERR;
                        end
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bitcnt_q    <= '0;
            len_q       <= '0;
            wr_adr_q    <= '0;
            shift_q     <= '0;
            cpu_reset_q <= 1'b1;
            load_busy_q <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            len_q       <= len_d;
            wr_adr_q    <= wr_adr_d;
            shift_q     <= shift_d;
            cpu_reset_q <= (state_d != S_RUN);
            load_busy_q <= (state_d == S_LEN) || (state_d == S_LOAD);
            load_done_q <= (state_d == S_RUN) && (state_q != S_RUN);
        end
    end

`ifdef LOADER_PARITY_EN
    logic perr_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) perr_q <= 1'b0;
        else       perr_q <= (state_d == S_ERR);
    end
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    // Memory is deliberately outside the reset domain so a reset keeps the loaded program.
    always_ff @(posedge clk) begin
        if (we) mem[wr_adr_q] <= wdata;
    end

    assign instruct  = mem[cpu_adr];
    assign cpu_reset = cpu_reset_q;
    assign load_busy = load_busy_q;
    assign load_done = load_done_q;

endmodule
